// File: rtl/tlbmiss_replay_q_pkg.sv
// Shared definitions for the TLB-miss replay queue: default address geometry
// and the head-of-queue FSM encoding.
package tlbmiss_replay_q_pkg;

    localparam int VADDR_W_DEF = 44;
    localparam int PAGE_SH_DEF = 14;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_SCAN   = 3'd1;
    localparam state_t ST_REQ    = 3'd2;
    localparam state_t ST_REPLAY = 3'd3;
    localparam state_t ST_DROP   = 3'd4;

endpackage

// File: rtl/tlbmiss_row_ram.sv
// Row storage for the replay queue: one synchronous write port, one
// combinational read port that always presents the head row.
module tlbmiss_row_ram #(
    parameter int DEPTH = 8,
    parameter int W     = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_r [DEPTH];

    // row write on enqueue; contents are only meaningful under the live bits
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/tlbmiss_replay_q.sv
// Queue of DTLB-missed memory-op rows: walks the L2 TLB one page per request
// for the head row, then replays the row once all live slots are translated.
module tlbmiss_replay_q
    import tlbmiss_replay_q_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 8,
    parameter int MOP_W    = 96,
    parameter int VADDR_W  = VADDR_W_DEF,
    parameter int PAGE_SH  = PAGE_SH_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enq_valid,
    output logic                        enq_ready,
    input  logic [CHANNELS-1:0]         enq_miss,
    input  logic [CHANNELS-1:0]         enq_thread,
    input  logic [CHANNELS*VADDR_W-1:0] enq_addr,
    input  logic [CHANNELS*MOP_W-1:0]   enq_mop,
    input  logic                        except,
    input  logic                        except_thread,
    output logic                        busy,
    output logic                        tlbreq_en,
    output logic [VADDR_W-PAGE_SH-1:0]  tlbreq_addr,
    input  logic                        tlbreq_ack,
    output logic [CHANNELS-1:0]         rep_valid,
    input  logic                        rep_ready,
    output logic [CHANNELS-1:0]         rep_thread,
    output logic [CHANNELS*VADDR_W-1:0] rep_addr,
    output logic [CHANNELS*MOP_W-1:0]   rep_mop
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = VADDR_W - PAGE_SH;
    localparam int SW = VADDR_W + 1 + MOP_W;
    localparam int RW = CHANNELS * SW;
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [AW-1:0]       wr_ptr_r;
    logic [AW-1:0]       rd_ptr_r;
    logic [AW:0]         count_r;
    state_t              state_r;
    state_t              state_nxt_s;
    state_t              scan_tgt_s;
    logic [CW-1:0]       sel_r;
    logic [CW-1:0]       sel_nxt_s;
    logic [CW-1:0]       scan_sel_s;
    logic [PW-1:0]       tlbreq_addr_r;
    logic [CHANNELS-1:0] live_r   [DEPTH];
    logic [CHANNELS-1:0] done_r   [DEPTH];
    logic [CHANNELS-1:0] thread_r [DEPTH];
    logic [CHANNELS-1:0] kill_s   [DEPTH];
    logic [CHANNELS-1:0] enq_kill_s;
    logic [CHANNELS-1:0] head_live_s;
    logic [CHANNELS-1:0] pend_s;
    logic [CHANNELS-1:0] mark_s;
    logic [CHANNELS-1:0] head_thread_s;
    logic                enq_fire_s;
    logic                pop_s;
    logic [RW-1:0]       wr_row_s;
    logic [RW-1:0]       head_row_s;
    logic [VADDR_W-1:0]  head_addr_s [CHANNELS];
    logic [MOP_W-1:0]    head_mop_s  [CHANNELS];
    logic [PW-1:0]       head_page_s [CHANNELS];

    assign enq_ready   = (count_r != (AW+1)'(DEPTH));
    assign enq_fire_s  = enq_valid & enq_ready & (|enq_miss);
    assign busy        = (count_r != '0) | (enq_valid & (|enq_miss));
    assign tlbreq_en   = (state_r == ST_REQ);
    assign tlbreq_addr = tlbreq_addr_r;

    // thread-selective flush masks for stored rows and for the incoming row
    always_comb begin
        enq_kill_s = except ? ~(enq_thread ^ {CHANNELS{except_thread}}) : '0;
        for (int r = 0; r < DEPTH; r++) begin
            kill_s[r] = except ? ~(thread_r[r] ^ {CHANNELS{except_thread}}) : '0;
        end
    end

    // pack the incoming row and unpack the head row into per-slot fields
    always_comb begin
        wr_row_s      = '0;
        head_thread_s = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            wr_row_s[c*SW +: SW] = {enq_thread[c], enq_addr[c*VADDR_W +: VADDR_W],
                                    enq_mop[c*MOP_W +: MOP_W]};
            head_mop_s[c]    = head_row_s[c*SW +: MOP_W];
            head_addr_s[c]   = head_row_s[c*SW + MOP_W +: VADDR_W];
            head_thread_s[c] = head_row_s[c*SW + SW - 1];
            head_page_s[c]   = head_addr_s[c][VADDR_W-1:PAGE_SH];
        end
    end

    tlbmiss_row_ram #(
        .DEPTH (DEPTH),
        .W     (RW)
    ) u_row_ram (
        .clk   (clk),
        .we    (enq_fire_s),
        .waddr (wr_ptr_r),
        .wdata (wr_row_s),
        .raddr (rd_ptr_r),
        .rdata (head_row_s)
    );

    // head-row view with this cycle's flush applied; lowest pending slot wins
    always_comb begin
        head_live_s = live_r[rd_ptr_r] & ~kill_s[rd_ptr_r];
        pend_s      = head_live_s & ~done_r[rd_ptr_r];
        scan_sel_s  = '0;
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            scan_sel_s = pend_s[c] ? CW'(c) : scan_sel_s;
        end
        scan_tgt_s = (|pend_s) ? ST_REQ : ((|head_live_s) ? ST_REPLAY : ST_DROP);
    end

    // head FSM; IDLE evaluates the scan itself so a fresh row reaches REQ in two cycles
    always_comb begin
        state_nxt_s = state_r;
        sel_nxt_s   = sel_r;
        pop_s       = 1'b0;
        mark_s      = '0;
        case (state_r)
            ST_IDLE: begin
                if (count_r != '0) begin
                    state_nxt_s = scan_tgt_s;
                    sel_nxt_s   = scan_sel_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                state_nxt_s = scan_tgt_s;
                sel_nxt_s   = scan_sel_s;
            end
            ST_REQ: begin
                if (!head_live_s[sel_r]) begin
                    state_nxt_s = ST_SCAN;
                end else if (tlbreq_ack) begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        mark_s[c] = head_live_s[c] & (head_page_s[c] == head_page_s[sel_r]);
                    end
                    state_nxt_s = ST_SCAN;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_REPLAY: begin
                if (head_live_s == '0) begin
                    state_nxt_s = ST_DROP;
                end else if (rep_ready) begin
                    pop_s       = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_REPLAY;
                end
            end
            ST_DROP: begin
                pop_s       = 1'b1;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // pointers, occupancy, FSM state and the registered request page
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            count_r       <= '0;
            state_r       <= ST_IDLE;
            sel_r         <= '0;
            tlbreq_addr_r <= '0;
        end else begin
            state_r       <= state_nxt_s;
            sel_r         <= sel_nxt_s;
            tlbreq_addr_r <= (state_nxt_s == ST_REQ) ? head_page_s[sel_nxt_s] : '0;
            if (enq_fire_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            if (enq_fire_s && !pop_s) begin
                count_r <= count_r + (AW+1)'(1);
            end else if (!enq_fire_s && pop_s) begin
                count_r <= count_r - (AW+1)'(1);
            end
        end
    end

    // per-slot live/done/thread flops, kept out of the RAM so flush hits all rows at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                live_r[r]   <= '0;
                done_r[r]   <= '0;
                thread_r[r] <= '0;
            end
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                if (enq_fire_s && (wr_ptr_r == AW'(r))) begin
                    live_r[r]   <= enq_miss & ~enq_kill_s;
                    done_r[r]   <= '0;
                    thread_r[r] <= enq_thread;
                end else begin
                    live_r[r] <= live_r[r] & ~kill_s[r];
                    done_r[r] <= (rd_ptr_r == AW'(r)) ? (done_r[r] | mark_s) : done_r[r];
                end
            end
        end
    end

    // replay outputs; a flush this cycle masks slots immediately
    always_comb begin
        rep_valid  = (state_r == ST_REPLAY) ? head_live_s : '0;
        rep_thread = head_thread_s & rep_valid;
        rep_addr   = '0;
        rep_mop    = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            rep_addr[c*VADDR_W +: VADDR_W] = rep_valid[c] ? head_addr_s[c] : '0;
            rep_mop[c*MOP_W +: MOP_W]      = rep_valid[c] ? head_mop_s[c] : '0;
        end
    end

endmodule
